// File: rtl/lcd_i2c_master_if.sv
// lcd_i2c_master_if: Avalon register port and I2C line signals of the LCD I2C master.
interface lcd_i2c_master_if;
    logic [1:0] address;
    logic       chipselect;
    logic       write_n;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       i2c_en;
    logic       sda_in;
    logic       sda_oe;
    logic       scl;
    modport slave (
        input  address, chipselect, write_n, writedata, i2c_en, sda_in,
        output readdata, sda_oe, scl
    );
    modport master (
        output address, chipselect, write_n, writedata, i2c_en, sda_in,
        input  readdata, sda_oe, scl
    );
endinterface

// File: rtl/lcd_i2c_master.sv
// lcd_i2c_master: single-byte I2C write master (START, addr+W, data, STOP) behind Avalon registers.
// Define LCD_I2C_ACK_CHECK_EN to abort to STOP and flag nack_err when the slave NACKs.
module lcd_i2c_master #(
    parameter int unsigned CLK_DIV = 125
) (
    input logic            clk,
    input logic            reset_n,
    lcd_i2c_master_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP} state_e;
`ifdef LCD_I2C_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif
    state_e      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  quar_q, quar_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d, data_q, data_d;
    logic [6:0]  slave_q, slave_d;
    logic        nack_q, nack_d, err_q, err_d;
    logic        busy, tick, wr, in_ack, scl_c, sda_oe_c;
    assign busy   = state_q != IDLE;
    assign tick   = busy && div_q == 16'(CLK_DIV - 1);
    assign wr     = bus.chipselect && !bus.write_n;
    assign in_ack = state_q == ACK1 || state_q == ACK2;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            quar_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            slave_q <= '0;
            nack_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            quar_q  <= quar_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            slave_q <= slave_d;
            nack_q  <= nack_d;
            err_q   <= err_d;
        end
    end
    // quar_q, bit_q and div_q all wrap back to 0 by the end of STOP, so a new transfer needs no reinit
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        quar_d  = quar_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        slave_d = slave_q;
        nack_d  = nack_q;
        err_d   = err_q;
        if (wr && bus.address == 2'd1) slave_d = bus.writedata[6:0];
        if (wr && bus.address == 2'd2 && bus.writedata[1]) err_d = 1'b0;
        if (busy) div_d = tick ? '0 : div_q + 16'd1;
        if (wr && bus.address == 2'd0 && !busy && bus.i2c_en) begin
            state_d = START;
            data_d  = bus.writedata;
            shift_d = {slave_q, 1'b0};
        end
        if (tick) begin
            quar_d = quar_q + 2'd1;
            // a set on the same cycle as a clear write wins
            if (ACK_CHECK && in_ack && quar_q == 2'd2) begin
                nack_d = bus.sda_in;
                if (bus.sda_in) err_d = 1'b1;
            end
            if (quar_q == 2'd3) begin
                if (state_q == ADDR || state_q == DATA) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                end
                case (state_q)
                    START:   state_d = ADDR;
                    ADDR:    state_d = &bit_q ? ACK1 : ADDR;
                    ACK1: begin
                        state_d = (ACK_CHECK && nack_q) ? STOP : DATA;
                        shift_d = data_q;
                    end
                    DATA:    state_d = &bit_q ? ACK2 : DATA;
                    ACK2:    state_d = STOP;
                    default: state_d = IDLE;
                endcase
            end
        end
    end
    always_comb begin
        scl_c    = 1'b1;
        sda_oe_c = 1'b0;
        case (state_q)
            START: begin
                scl_c    = quar_q != 2'd3;
                sda_oe_c = quar_q[1];
            end
            ADDR, DATA: begin
                scl_c    = quar_q == 2'd1 || quar_q == 2'd2;
                sda_oe_c = !shift_q[7];
            end
            ACK1, ACK2: scl_c = quar_q == 2'd1 || quar_q == 2'd2;
            STOP: begin
                scl_c    = quar_q != 2'd0;
                sda_oe_c = !quar_q[1];
            end
            default: ;
        endcase
    end
    assign bus.scl      = scl_c;
    assign bus.sda_oe   = sda_oe_c;
    assign bus.readdata = bus.address == 2'd0 ? data_q :
                          bus.address == 2'd1 ? {1'b0, slave_q} :
                          bus.address == 2'd2 ? {6'd0, err_q, busy} : 8'h00;
endmodule

// File: tb/tb_lcd_i2c_master.sv
// tb_lcd_i2c_master: scoreboard bench; a bus monitor decodes START/bytes/STOP and checks them against queued expectations.
module tb_lcd_i2c_master;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ack_pull = 1'b0;
    logic nack_en = 1'b0;
    logic mon_en = 1'b1;
    logic p_scl = 1'b1;
    logic p_sda = 1'b1;
    logic [7:0] sh = '0;
    int bitcnt = 0;
    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];
    localparam logic [8:0] EV_START = 9'h100;
    localparam logic [8:0] EV_STOP  = 9'h101;

    lcd_i2c_master_if bus();
    lcd_i2c_master #(.CLK_DIV(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;
    assign bus.sda_in = ~(bus.sda_oe | ack_pull);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic ev(input logic [8:0] got);
        if (!mon_en) return;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL bus_event: got %0h expected none", got);
        end else check("bus_event", got, exp_q.pop_front());
    endtask

    // Bus monitor and ACK-responding slave, sampled away from the active edge
    always @(negedge clk) begin
        logic line;
        line = ~(bus.sda_oe | ack_pull);
        if (bus.scl && p_scl && p_sda && !line) begin
            bitcnt = 0;
            ev(EV_START);
        end else if (bus.scl && p_scl && !p_sda && line) begin
            bitcnt = 0;
            ev(EV_STOP);
        end else if (bus.scl && !p_scl) begin
            if (bitcnt < 8) begin
                sh = {sh[6:0], line};
                bitcnt++;
                if (bitcnt == 8) ev({1'b0, sh});
            end else bitcnt = 0;
        end else if (!bus.scl && p_scl) ack_pull = (bitcnt == 8) && !nack_en;
        p_scl = bus.scl;
        p_sda = line;
    end

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.address = a;
        bus.writedata = d;
        bus.chipselect = 1'b1;
        bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
        bus.address = 2'd2;
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        bus.address = a;
        bus.chipselect = 1'b1;
        #1 d = bus.readdata;
        bus.address = 2'd2;
        bus.chipselect = 1'b0;
    endtask

    task automatic push_xfer(input logic [7:0] a, input logic [7:0] d, input bit full);
        exp_q.push_back(EV_START);
        exp_q.push_back({1'b0, a});
        if (full) exp_q.push_back({1'b0, d});
        exp_q.push_back(EV_STOP);
    endtask

    // Counts cycles of busy; with mid set it also pokes DATA, SLAVE and i2c_en mid-transfer
    task automatic busy_len(input bit mid, output int n);
        n = 0;
        while (bus.readdata[0] && n < 2000) begin
            n++;
            if (mid && n == 50) begin
                bus.address = 2'd0; bus.writedata = 8'h11; bus.chipselect = 1'b1; bus.write_n = 1'b0;
            end
            if (mid && n == 100) begin
                bus.address = 2'd1; bus.writedata = 8'h55; bus.chipselect = 1'b1; bus.write_n = 1'b0;
            end
            if (mid && n == 150) bus.i2c_en = 1'b0;
            @(negedge clk);
            bus.chipselect = 1'b0;
            bus.write_n = 1'b1;
            bus.address = 2'd2;
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int n;
        bus.address = 2'd2;
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
        bus.writedata = 8'h00;
        bus.i2c_en = 1'b1;
        #3;
        check("reset_scl", bus.scl, 1);
        check("reset_sda_oe", bus.sda_oe, 0);
        check("reset_status", bus.readdata, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        rd(2'd1, d); check("reset_slave", d, 8'h00);
        rd(2'd3, d); check("addr3_read", d, 8'h00);

        wr(2'd1, 8'h27);
        rd(2'd1, d); check("slave_rw", d, 8'h27);
        push_xfer(8'h4E, 8'hA5, 1);
        wr(2'd0, 8'hA5);
        check("busy_next_cycle", bus.readdata[0], 1);
        busy_len(0, n);
        check("busy_cycles_a5", n, 320);
        check("nack_err_clear_a5", bus.readdata[1], 0);

        bus.i2c_en = 1'b0;
        wr(2'd0, 8'h3C);
        repeat (10) @(negedge clk);
        #1;
        check("disabled_busy", bus.readdata[0], 0);
        check("disabled_scl", bus.scl, 1);
        check("disabled_sda_oe", bus.sda_oe, 0);
        bus.i2c_en = 1'b1;

        push_xfer(8'h4E, 8'hA5, 1);
        wr(2'd0, 8'hA5);
        busy_len(1, n);
        check("busy_cycles_mid_writes", n, 320);
        rd(2'd1, d); check("slave_written_during_busy", d, 8'h55);
        bus.i2c_en = 1'b1;
        wr(2'd1, 8'h27);

        nack_en = 1'b1;
`ifdef LCD_I2C_ACK_CHECK_EN
        push_xfer(8'h4E, 8'h5A, 0);
        wr(2'd0, 8'h5A);
        busy_len(0, n);
        check("busy_cycles_nack", n, 176);
        check("nack_err_set", bus.readdata[1], 1);
`else
        push_xfer(8'h4E, 8'h5A, 1);
        wr(2'd0, 8'h5A);
        busy_len(0, n);
        check("busy_cycles_nack", n, 320);
        check("nack_err_set", bus.readdata[1], 0);
`endif
        nack_en = 1'b0;
        wr(2'd2, 8'h02);
        check("nack_err_cleared", bus.readdata[1], 0);

        mon_en = 1'b0;
        wr(2'd0, 8'hA5);
        repeat (182) @(negedge clk);
        #1;
        check("pre_reset_scl", bus.scl, 1);
        check("pre_reset_sda_oe", bus.sda_oe, 1);
        reset_n = 1'b0;
        #1;
        check("async_reset_scl", bus.scl, 1);
        check("async_reset_sda_oe", bus.sda_oe, 0);
        check("async_reset_busy", bus.readdata[0], 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        #1;
        rd(2'd1, d); check("slave_after_reset", d, 8'h00);
        wr(2'd1, 8'h27);
        push_xfer(8'h4E, 8'hC3, 1);
        wr(2'd0, 8'hC3);
        busy_len(0, n);
        check("busy_cycles_after_reset", n, 320);

        repeat (8) @(negedge clk);
        check("events_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lcd_i2c_master.md
LCD_I2C_MASTER -- requirements
Module: lcd_i2c_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, giving clk cycles per quarter SCL period (range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port address  input  2  Avalon slave register select.
REQ-005 SHALL have port chipselect  input  1  slave select.
REQ-006 SHALL have port write_n  input  1  active-low write strobe.
REQ-007 SHALL have port writedata  input  8  write data.
REQ-008 SHALL have port readdata  output  8  combinational read mux.
REQ-009 SHALL have port i2c_en  input  1  enable bit from the upstream LCD I2C enable PIO.
REQ-010 SHALL have port sda_in  input  1  sampled SDA line.
REQ-011 SHALL have port sda_oe  output  1  1 = pull SDA low; 0 = release.
REQ-012 SHALL have port scl  output  1  SCL drive level; 1 = released/high.

Function
REQ-013 SHALL decode registers: addr0 DATA (W: byte, starts transfer), addr1 SLAVE (RW: bits[6:0] 7-bit address), addr2 STATUS (R: bit0 busy, bit1 nack_err; W: bit1=1 clears nack_err), addr3 reads 0x00.
REQ-014 SHALL define a write as chipselect=1 and write_n=0 in one cycle.
REQ-015 SHALL start a transfer on a DATA write only when busy=0 and i2c_en=1; otherwise SHALL drop the write with no side effect.
REQ-016 SHALL assert busy on the cycle after the accepted DATA write.
REQ-017 SHALL keep busy=1 until the STOP phase ends and then return to IDLE.
REQ-018 SHALL use a divider that produces a one-cycle tick every CLK_DIV cycles while busy; each state phase SHALL last 4 ticks (quarters q0..q3).
REQ-019 SHALL use states and order IDLE -> START -> ADDR(8 bits: SLAVE[6:0] MSB first, then R/W=0) -> ACK1 -> DATA(8 bits MSB first) -> ACK2 -> STOP -> IDLE.
REQ-020 SHALL drive START as: q0-q1 SDA released, SCL high; q2 SDA low, SCL high; q3 SDA low, SCL low.
REQ-021 SHALL drive each bit phase as: q0 SCL low with SDA changing to the bit; q1-q2 SCL high; q3 SCL low; SDA stable from q0 to q3.
REQ-022 SHALL release SDA during the ACK phases and sample sda_in at the end of q2; sda_in=1 is a NACK.
REQ-023 SHALL drive STOP as: q0 SCL low, SDA low; q1 SCL high; q2-q3 SCL high, SDA released.
REQ-024 SHALL take 80 quarter periods (80*CLK_DIV cycles of busy) for a full transfer.
REQ-025 SHALL NOT abort an in-progress transfer when i2c_en falls; the transfer completes.
REQ-026 SHALL latch DATA and SLAVE at transfer start; SLAVE writes during busy SHALL update the register but not the current transfer.
REQ-027 SHALL give clear-priority to nack_err set over a simultaneous STATUS clear write.

Reset
REQ-028 SHALL, while reset_n=0: force state IDLE, busy=0, nack_err=0, divider=0, SLAVE=0x00, DATA shadow=0x00, scl=1, sda_oe=0.
REQ-029 SHALL, on reset mid-transfer, release both lines immediately with no STOP generated.

Configuration
REQ-030 SHALL, with LCD_I2C_ACK_CHECK_EN defined, on a NACK in ACK1 or ACK2 set nack_err=1 and go directly to STOP; a NACK in ACK1 gives 44 quarters of busy.
REQ-031 SHALL, without LCD_I2C_ACK_CHECK_EN, ignore sda_in, hold nack_err at 0, and always complete in 80 quarters.

Verification
REQ-032 SHALL verify: CLK_DIV=4, i2c_en=1, SLAVE=0x27, DATA write 0xA5, ACK driven low -> SDA bits 0x4E then 0xA5, START/STOP correct, busy high for 320 cycles.
REQ-033 SHALL verify: i2c_en=0, DATA write 0x3C -> busy stays 0, scl=1, sda_oe=0.
REQ-034 SHALL verify: second DATA write 0x11 during busy -> ignored; bus shows only the first byte.
REQ-035 SHALL verify: with the macro defined, sda_in=1 during ACK1 -> nack_err=1, STOP follows, busy for 176 cycles; STATUS write 0x02 clears it. Without the macro -> full 320 cycles and nack_err=0.
REQ-036 SHALL verify: reset_n pulsed low during the DATA phase -> scl=1, sda_oe=0 and busy=0 asynchronously; the next transfer runs normally.
